median_window_gen: RTL and testbench

//  Upstream stage of Filter_Median. Converts a raster 8-bit pixel stream into 5x5 neighbourhood windows.

---
 rtl/median_pkg.sv | 24 ++
 rtl/median_window_gen_if.sv | 45 ++++
 rtl/median_line_buffer.sv | 28 ++
 rtl/median_window_gen.sv | 174 +++++++++++++++++
 tb/tb_median_window_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared constants and helpers for the median filter datapath.
// Used by median_window_gen, Filter_Median and their benches.
//   PIX_W      bits per pixel
//   WIN_DIM    window edge length (5x5)
//   WIN_ELEMS  elements per window
//   WIN_BITS   packed window width
//   win_idx    element index of (row, col) inside a packed window
package median_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_DIM   = 5;
    localparam int WIN_ELEMS = WIN_DIM * WIN_DIM;
    localparam int WIN_BITS  = WIN_ELEMS * PIX_W;

    typedef logic [PIX_W-1:0]               pix_t;
    typedef logic [WIN_BITS-1:0]            win_t;
    // One column of the window, index 0 = oldest line.
    typedef logic [WIN_DIM-1:0][PIX_W-1:0] col_t;

    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / window-out handshake bundle for median_window_gen.
//   in_sof/in_pixel/in_valid/in_ready : raster pixel stream (valid/ready)
//   win_data/win_valid/win_ready      : 5x5 window stream (valid/ready)
//   win_cx/win_cy                     : window centre, only with WIN_CENTER_COORD_EN
// slave  = the window generator, master = the upstream/downstream environment.
interface median_window_gen_if #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    import median_pkg::*;

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic  in_sof;
    pix_t  in_pixel;
    logic  in_valid;
    logic  in_ready;
    win_t  win_data;
    logic  win_valid;
    logic  win_ready;
`ifdef WIN_CENTER_COORD_EN
    logic [XW-1:0] win_cx;
    logic [YW-1:0] win_cy;

    modport slave (
        input  in_sof, in_pixel, in_valid, win_ready,
        output in_ready, win_data, win_valid, win_cx, win_cy
    );
    modport master (
        output in_sof, in_pixel, in_valid, win_ready,
        input  in_ready, win_data, win_valid, win_cx, win_cy
    );
`else
    modport slave (
        input  in_sof, in_pixel, in_valid, win_ready,
        output in_ready, win_data, win_valid
    );
    modport master (
        output in_sof, in_pixel, in_valid, win_ready,
        input  in_ready, win_data, win_valid
    );
`endif

endinterface

// File: rtl/median_line_buffer.sv
// One line of pixel storage for the window generator.
//   clk   write clock
//   we    write enable (one write per accepted pixel)
//   addr  column address, shared by read and write
//   din   value written at addr
//   dout  value stored at addr before this cycle's write (read-before-write)
// No reset: contents are only meaningful once a line has been written.
module median_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    // Combinational read sees the old word; the write lands at the clock edge.
    assign dout = mem[addr];

endmodule

// File: rtl/median_window_gen.sv
// Raster pixel stream -> 5x5 neighbourhood windows for Filter_Median.
// Four line buffers supply the previous four lines at the current column;
// together with the incoming pixel they form a column pushed into a 5x5
// shift array. Every interior pixel (x>=4, y>=4) produces one window whose
// bottom-right corner is that pixel.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         median_window_gen_if.slave (pixel in, window out)
// Optional: WIN_CENTER_COORD_EN adds win_cx/win_cy (window centre x-2, y-2).
module median_window_gen
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    median_window_gen_if.slave   bus
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(WIN_DIM - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(WIN_DIM - 1);

    // Raster position of the next pixel.
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // Position of the pixel on the bus this cycle (sof forces the origin).
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    // Shift array indexed [row][col]; row 0 = oldest line, col 0 = leftmost.
    logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] arr_q, arr_d;

    win_t win_data_q, win_data_d;
    win_t win_pack;
    logic win_valid_q, win_valid_d;

    logic accept;
    logic emit;

    logic [WIN_DIM-2:0][PIX_W-1:0] lb_din;
    logic [WIN_DIM-2:0][PIX_W-1:0] lb_dout;
    col_t                          col_in;

    assign bus.in_ready = !win_valid_q || bus.win_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign cur_x = bus.in_sof ? '0 : x_q;
    assign cur_y = bus.in_sof ? '0 : y_q;

    assign emit = accept && (cur_x >= X_FIRST) && (cur_y >= Y_FIRST);

    // Each line buffer forwards its old word to the next one, so lbN holds
    // line y-1-N at column x.
    assign lb_din = {lb_dout[WIN_DIM-3:0], bus.in_pixel};

    for (genvar i = 0; i < WIN_DIM - 1; i++) begin : g_lb
        median_line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (PIX_W)
        ) u_lb (
            .clk  (clk),
            .we   (accept),
            .addr (cur_x),
            .din  (lb_din[i]),
            .dout (lb_dout[i])
        );
    end

    // Column rows y-4..y: oldest line at index 0, live pixel at index 4.
    assign col_in = {bus.in_pixel, lb_dout[0], lb_dout[1], lb_dout[2], lb_dout[3]};

    // Raster counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end
        end
    end

    // Shift array: move left one column, new column enters at col 4.
    always_comb begin
        arr_d = arr_q;
        if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM - 1; c++) begin
                    arr_d[r][c] = arr_q[r][c+1];
                end
                arr_d[r][WIN_DIM-1] = col_in[r];
            end
        end
    end

    // Window packing expected by Filter_Median.
    always_comb begin
        win_pack = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                win_pack[win_idx(r, c)*PIX_W +: PIX_W] = arr_d[r][c];
            end
        end
    end

    // Output register. While stalled, in_ready is low so emit cannot fire
    // and the window holds.
    always_comb begin
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        if (emit) begin
            win_data_d  = win_pack;
            win_valid_d = 1'b1;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            arr_q       <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            arr_q       <= arr_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign bus.win_data  = win_data_q;
    assign bus.win_valid = win_valid_q;

`ifdef WIN_CENTER_COORD_EN
    logic [XW-1:0] win_cx_q, win_cx_d;
    logic [YW-1:0] win_cy_q, win_cy_d;

    always_comb begin
        win_cx_d = win_cx_q;
        win_cy_d = win_cy_q;
        if (emit) begin
            win_cx_d = cur_x - XW'(2);
            win_cy_d = cur_y - YW'(2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cx_q <= '0;
            win_cy_q <= '0;
        end else begin
            win_cx_q <= win_cx_d;
            win_cy_q <= win_cy_d;
        end
    end

    assign bus.win_cx = win_cx_q;
    assign bus.win_cy = win_cy_q;
`endif

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen on an 8x6 frame. Expected windows are built
// from the pixel formula and queued when the emitting pixel is driven; the
// monitor pops one entry per window handshake.
module tb_median_window_gen;
    import median_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        win_t data;
        int   cx;
        int   cy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    median_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    win_t wins[$];
    int   cxs[$];
    int   cys[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_win  = 0;

    task automatic check(input string tag, input win_t got, input win_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic pix_t pix(input int base, input int x, input int y);
        return pix_t'(base + y * W + x);
    endfunction

    function automatic win_t model_win(input int base, input int x, input int y);
        win_t w = '0;
        for (int r = 0; r < WIN_DIM; r++)
            for (int c = 0; c < WIN_DIM; c++)
                w[win_idx(r, c)*PIX_W +: PIX_W] = pix(base, x - 4 + c, y - 4 + r);
        return w;
    endfunction

    function automatic int elem(input win_t w, input int k);
        return int'(w[k*PIX_W +: PIX_W]);
    endfunction

    // Window monitor: a handshake seen at the falling edge completes at the
    // next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.win_valid && bus.win_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_win", win_t'(bus.win_data), win_t'(0));
            end else begin
                e = exp_q.pop_front();
                check("win_data", bus.win_data, e.data);
`ifdef WIN_CENTER_COORD_EN
                check("win_cx", win_t'(bus.win_cx), win_t'(e.cx));
                check("win_cy", win_t'(bus.win_cy), win_t'(e.cy));
                cxs.push_back(int'(bus.win_cx));
                cys.push_back(int'(bus.win_cy));
`endif
            end
            wins.push_back(bus.win_data);
            n_win++;
        end
    end

    // Drive one pixel and return just after the edge that accepts it.
    task automatic drive(input int base, input int x, input int y, input logic sof);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = pix(base, x, y);
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("accept_timeout", win_t'(0), win_t'(1));
        if (x >= 4 && y >= 4) exp_q.push_back('{model_win(base, x, y), x - 2, y - 2});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic stream(input int base, input int first, input int last, input logic sof);
        for (int i = first; i <= last; i++)
            drive(base, i % W, i / W, sof && (i == first));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_win = 0;
        wins.delete();
        cxs.delete();
        cys.delete();
    endtask

    // Full frame from (0,0) with the spot checks for the first window,
    // second window row and last window.
    task automatic run_clean(input logic sof);
        clear_logs();
        stream(0, 0, 35, sof);
        check("lat_before", win_t'(bus.win_valid), win_t'(0));
        drive(0, 4, 4, 1'b0);
        check("lat_after", win_t'(bus.win_valid), win_t'(1));
        stream(0, 37, 47, 1'b0);
        idle(3);
        check("n_win", win_t'(n_win), win_t'(8));
        if (wins.size() == 8) begin
            check("w0_e0",  win_t'(elem(wins[0], 0)),  win_t'(0));
            check("w0_e12", win_t'(elem(wins[0], 12)), win_t'(18));
            check("w0_e24", win_t'(elem(wins[0], 24)), win_t'(36));
            check("w4_e0",  win_t'(elem(wins[4], 0)),  win_t'(8));
            check("w4_e24", win_t'(elem(wins[4], 24)), win_t'(44));
            check("w7_e24", win_t'(elem(wins[7], 24)), win_t'(47));
        end
`ifdef WIN_CENTER_COORD_EN
        if (cxs.size() == 8) begin
            check("first_cx", win_t'(cxs[0]), win_t'(2));
            check("first_cy", win_t'(cys[0]), win_t'(2));
            check("last_cx",  win_t'(cxs[7]), win_t'(5));
            check("last_cy",  win_t'(cys[7]), win_t'(3));
        end
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : seq
        win_t hold;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_pixel  = '0;
        bus.win_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", win_t'(bus.win_valid), win_t'(0));
        check("rst_data",  bus.win_data, win_t'(0));
`ifdef WIN_CENTER_COORD_EN
        check("rst_cx", win_t'(bus.win_cx), win_t'(0));
        check("rst_cy", win_t'(bus.win_cy), win_t'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Plain frame, no sof (counters start at the origin after reset)
        run_clean(1'b0);

        // Back-pressure right after the first window
        clear_logs();
        stream(0, 0, 36, 1'b1);
        bus.win_ready = 1'b0;
        hold = bus.win_data;
        check("stall_first", win_t'(elem(hold, 24)), win_t'(36));
        bus.in_valid = 1'b1;
        bus.in_pixel = pix(0, 5, 4);
        repeat (5) begin
            @(negedge clk);
            check("stall_data",  bus.win_data, hold);
            check("stall_valid", win_t'(bus.win_valid), win_t'(1));
            check("stall_ready", win_t'(bus.in_ready), win_t'(0));
        end
        @(posedge clk);
        #1;
        bus.win_ready = 1'b1;
        stream(0, 37, 47, 1'b0);
        idle(3);
        check("stall_n_win", win_t'(n_win), win_t'(8));
        if (wins.size() >= 2)
            check("stall_next", win_t'(elem(wins[1], 24)), win_t'(37));

        // Abort at (3,4) with sof, new frame with different pixel values
        clear_logs();
        stream(0, 0, 34, 1'b1);
        stream(100, 0, 47, 1'b1);
        idle(3);
        check("sof_n_win", win_t'(n_win), win_t'(8));
        if (wins.size() >= 1) begin
            check("sof_e0",  win_t'(elem(wins[0], 0)),  win_t'(100));
            check("sof_e24", win_t'(elem(wins[0], 24)), win_t'(136));
        end

        // Asynchronous reset in the middle of the window stream
        stream(0, 0, 40, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", win_t'(bus.win_valid), win_t'(0));
        check("arst_data",  bus.win_data, win_t'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        run_clean(1'b0);

        check("q_empty", win_t'(exp_q.size()), win_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
